// File: rtl/mul8_seq_ctrl_if.sv
// rtl/mul8_seq_ctrl_if.sv - operand/result handshakes and shared 4x4 core hookup for mul8_seq_ctrl
interface mul8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  mul_m;
  logic [3:0]  mul_q;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        busy;

  modport master (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_m, mul_q, out_valid, out_prod, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_m, mul_q, out_valid, out_prod, busy
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over an external shared 4x4 core
module mul8_seq_ctrl #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mul8_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [15:0] acc;
  logic        out_valid_r;
  logic        busy_r;
  logic [15:0] partial;

  // step[0] picks the a nibble, step[1] the b nibble: lo/lo, hi/lo, lo/hi, hi/hi
  always_comb begin
    bus.mul_m = 4'h0;
    bus.mul_q = 4'h0;
    if (state == STEP) begin
      bus.mul_m = step[0] ? a_reg[7:4] : a_reg[3:0];
      bus.mul_q = step[1] ? b_reg[7:4] : b_reg[3:0];
    end
  end

  always_comb begin
    partial = {8'h00, bus.mul_p};
    case (step)
      2'd0:    partial = {8'h00, bus.mul_p};
      2'd1,
      2'd2:    partial = {4'h0, bus.mul_p, 4'h0};
      default: partial = {bus.mul_p, 8'h00};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      step        <= 2'd0;
      a_reg       <= 8'h00;
      b_reg       <= 8'h00;
      acc         <= 16'h0000;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg  <= bus.in_a;
            b_reg  <= bus.in_b;
            acc    <= 16'h0000;
            step   <= 2'd0;
            busy_r <= 1'b1;
            if (ZERO_SKIP && (bus.in_a == 8'h00 || bus.in_b == 8'h00)) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          acc  <= acc + partial;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Held off during reset so nothing is accepted until the first cycle after release
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_prod  = acc;

endmodule
